// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage RV32I pipe: stall/bubble/flush/hold and forwarding selects.
// Optional HAZ_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_sched #(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_ins,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        stall_if,
   output logic        stall_id,
   output logic        bubble_ex,
   output logic        flush_if_id,
   output logic        pipe_hold,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       is_load;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } stage_t;

   state_t     state, prior, eff;
   logic [2:0] cnt;
   stage_t     ex, mem, wb, id_e;
   logic       uses_rs1, uses_rs2, writes;
   logic       load_use, flushing;

   logic unused_ok;
   assign unused_ok = ^{id_ins[31:25], id_ins[14:12], mem.is_load, mem.rs1, mem.rs2,
                        wb.is_load, wb.rs1, wb.rs2};

   always_comb begin
      writes   = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (id_ins[6:0])
         OPC_OP:                 begin writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OPC_OP_IMM, OPC_LOAD,
         OPC_JALR:               begin writes = 1'b1; uses_rs1 = 1'b1; end
         OPC_LUI, OPC_AUIPC,
         OPC_JAL:                writes = 1'b1;
         OPC_STORE, OPC_BRANCH:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         default:                ;
      endcase
      id_e.valid   = id_valid;
      id_e.rd      = id_ins[11:7];
      id_e.wr      = writes && (id_ins[11:7] != 5'd0);
      id_e.is_load = (id_ins[6:0] == OPC_LOAD);
      id_e.rs1     = id_ins[19:15];
      id_e.rs2     = id_ins[24:20];
   end

   // HOLD only remembers that memory was busy; once released we behave as the prior state.
   assign eff = (state == HOLD) ? prior : state;

   always_comb begin
      flushing = branch_taken || (eff == FLUSH);
      load_use = ex.valid && ex.is_load && ex.wr && id_valid &&
                 ((uses_rs1 && (id_e.rs1 == ex.rd)) || (uses_rs2 && (id_e.rs2 == ex.rd)));
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      pipe_hold   = 1'b0;
      if (rst) begin
         // outputs forced low while reset is asserted
      end else if (mem_busy) begin
         pipe_hold = 1'b1;
         stall_if  = 1'b1;
         stall_id  = 1'b1;
      end else if (flushing) begin
         flush_if_id = 1'b1;
         bubble_ex   = 1'b1;
      end else if (load_use) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         bubble_ex = 1'b1;
      end
   end

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input stage_t e,
                                          input stage_t m, input stage_t w);
      if (!e.valid)                       return 2'b00;
      if (m.valid && m.wr && m.rd == rs)  return 2'b10;
      if (w.valid && w.wr && w.rd == rs)  return 2'b01;
      return 2'b00;
   endfunction

   assign fwd_a_sel = rst ? 2'b00 : fwd_sel(ex.rs1, ex, mem, wb);
   assign fwd_b_sel = rst ? 2'b00 : fwd_sel(ex.rs2, ex, mem, wb);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         prior <= RUN;
         cnt   <= '0;
         ex    <= '0;
         mem   <= '0;
         wb    <= '0;
      end else if (mem_busy) begin
         if (state != HOLD) prior <= state;
         state <= HOLD;
      end else begin
         case (eff)
            RUN: begin
               if (branch_taken && FLUSH_CYCLES > 1) begin
                  state <= FLUSH;
                  cnt   <= CNT_LOAD;
               end else begin
                  state <= RUN;
               end
            end
            FLUSH: begin
               if (branch_taken) begin
                  state <= FLUSH;
                  cnt   <= CNT_LOAD;
               end else if (cnt <= 3'd1) begin
                  state <= RUN;
                  cnt   <= '0;
               end else begin
                  state <= FLUSH;
                  cnt   <= cnt - 3'd1;
               end
            end
            default: state <= RUN;
         endcase
         ex  <= (bubble_ex || !id_valid) ? '0 : id_e;
         mem <= ex;
         wb  <= mem;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && bubble_ex && !flush_if_id && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
         if (flush_if_id && flush_cnt != '1)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed-vector bench for hazard_sched with FLUSH_CYCLES=2.
module tb_hazard_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_ins;
   logic        branch_taken;
   logic        mem_busy;
   logic        stall_if, stall_id, bubble_ex, flush_if_id, pipe_hold;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   hazard_sched #(.FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ins(id_ins),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .flush_if_id(flush_if_id), .pipe_hold(pipe_hold),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // ctl = {stall_if, stall_id, bubble_ex, flush_if_id, pipe_hold}
   localparam logic [4:0] C_NONE  = 5'b00000;
   localparam logic [4:0] C_LDUSE = 5'b11100;
   localparam logic [4:0] C_FLUSH = 5'b00110;
   localparam logic [4:0] C_HOLD  = 5'b11001;

   function automatic logic [31:0] r_ins(input logic [4:0] rd, rs1, rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_ins(input logic [6:0] opc, input logic [4:0] rd, rs1);
      return {12'd1, rs1, 3'b010, rd, opc};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic v, input logic [31:0] ins,
                       input logic br, input logic busy,
                       input logic [4:0] ctl_e, input logic [3:0] fwd_e);
      id_valid = v; id_ins = ins; branch_taken = br; mem_busy = busy;
      #2;
      check({tag, ".ctl"}, {3'b0, stall_if, stall_id, bubble_ex, flush_if_id, pipe_hold}, {3'b0, ctl_e});
      check({tag, ".fwd"}, {4'b0, fwd_a_sel, fwd_b_sel}, {4'b0, fwd_e});
      tick();
   endtask

   task automatic drain();
      id_valid = 1'b0; id_ins = '0; branch_taken = 1'b0; mem_busy = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_ins = '0; branch_taken = 1'b0; mem_busy = 1'b0;
      #12;
      check("reset.ctl", {3'b0, stall_if, stall_id, bubble_ex, flush_if_id, pipe_hold}, 8'd0);
      check("reset.fwd", {4'b0, fwd_a_sel, fwd_b_sel}, 8'd0);
      @(posedge clk); #1; rst = 1'b0;

      // back-to-back dependency: add x5; sub x6,x5,x3; or x10,x4,x5
      step("dep0", 1, r_ins(5, 1, 2), 0, 0, C_NONE, 4'b0000);
      step("dep1", 1, r_ins(6, 5, 3), 0, 0, C_NONE, 4'b0000);
      step("dep2", 1, r_ins(10, 4, 5), 0, 0, C_NONE, 4'b1000);
      step("dep3", 0, 32'd0, 0, 0, C_NONE, 4'b0001);
      drain();

      // load-use: lw x7; add x8,x7,x2
      step("lu0", 1, i_ins(7'b0000011, 7, 1), 0, 0, C_NONE, 4'b0000);
      step("lu1", 1, r_ins(8, 7, 2), 0, 0, C_LDUSE, 4'b0000);
      step("lu2", 1, r_ins(8, 7, 2), 0, 0, C_NONE, 4'b0000);
      step("lu3", 0, 32'd0, 0, 0, C_NONE, 4'b0100);
      drain();

      // x0 destination never forwards
      step("x0a", 1, i_ins(7'b0010011, 0, 0), 0, 0, C_NONE, 4'b0000);
      step("x0b", 1, r_ins(9, 0, 0), 0, 0, C_NONE, 4'b0000);
      step("x0c", 0, 32'd0, 0, 0, C_NONE, 4'b0000);
      drain();

      // taken branch squashes a pending load-use, flush lasts 2 cycles
      step("br0", 1, i_ins(7'b0000011, 7, 1), 0, 0, C_NONE, 4'b0000);
      step("br1", 1, r_ins(8, 7, 2), 1, 0, C_FLUSH, 4'b0000);
      step("br2", 1, r_ins(8, 7, 2), 0, 0, C_FLUSH, 4'b0000);
      step("br3", 0, 32'd0, 0, 0, C_NONE, 4'b0000);
      drain();

      // mem_busy 3 cycles over a load-use window, then the stall
      step("mb0", 1, i_ins(7'b0000011, 7, 1), 0, 0, C_NONE, 4'b0000);
      step("mb1", 1, r_ins(8, 7, 2), 0, 1, C_HOLD, 4'b0000);
      step("mb2", 1, r_ins(8, 7, 2), 0, 1, C_HOLD, 4'b0000);
      step("mb3", 1, r_ins(8, 7, 2), 0, 1, C_HOLD, 4'b0000);
      step("mb4", 1, r_ins(8, 7, 2), 0, 0, C_LDUSE, 4'b0000);
      step("mb5", 1, r_ins(8, 7, 2), 0, 0, C_NONE, 4'b0000);
      step("mb6", 0, 32'd0, 0, 0, C_NONE, 4'b0100);
      drain();

      // mem_busy mid-flush pauses the count
      step("fh0", 0, 32'd0, 1, 0, C_FLUSH, 4'b0000);
      step("fh1", 0, 32'd0, 0, 1, C_HOLD, 4'b0000);
      step("fh2", 0, 32'd0, 0, 0, C_FLUSH, 4'b0000);
      step("fh3", 0, 32'd0, 0, 0, C_NONE, 4'b0000);

      // async reset mid-flush
      step("rf0", 0, 32'd0, 1, 0, C_FLUSH, 4'b0000);
      branch_taken = 1'b0;
      #2;
      check("rf1.ctl", {3'b0, stall_if, stall_id, bubble_ex, flush_if_id, pipe_hold}, {3'b0, C_FLUSH});
      rst = 1'b1;
      #1;
      check("rf2.ctl", {3'b0, stall_if, stall_id, bubble_ex, flush_if_id, pipe_hold}, 8'd0);
      tick();
      rst = 1'b0;
      step("rf3", 1, r_ins(5, 1, 2), 0, 0, C_NONE, 4'b0000);
      step("rf4", 1, r_ins(6, 5, 3), 0, 0, C_NONE, 4'b0000);
      step("rf5", 0, 32'd0, 0, 0, C_NONE, 4'b1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage RV32I core. Sits beside the IF/ID/EX/MEM/WB pipeline registers.
- Decodes the instruction in ID using the standard RV32I field slicing, and keeps a shadow scoreboard of destination registers in flight in EX/MEM/WB.
- Generates stall, bubble, flush and forwarding-select controls for the datapath. Holds the whole pipe while the data memory is busy.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles flush_if_id is asserted per taken branch/jump, including the resolving cycle; legal range 1..7.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_ins  input  32  instruction in ID
- branch_taken  input  1  EX resolved a taken branch/JAL/JALR this cycle
- mem_busy  input  1  data memory not ready; pipeline must freeze
- stall_if  output  1  hold PC and IF/ID register
- stall_id  output  1  hold ID/EX source fields
- bubble_ex  output  1  load NOP into ID/EX
- flush_if_id  output  1  squash IF/ID contents
- pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB
- fwd_a_sel  output  2  EX operand A source: 00 regfile, 01 WB, 10 MEM
- fwd_b_sel  output  2  EX operand B source, same encoding

Behaviour:
- Field slicing: opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
- writes_rd: opcode is OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111 or JALR 1100111, and rd≠0.
- uses_rs1: OP, OP-IMM, LOAD, STORE 0100011, BRANCH 1100011, JALR. uses_rs2: OP, STORE, BRANCH.
- Unknown opcodes write nothing and use nothing.
- Shadow stages ex/mem/wb each hold: valid, rd, wr, is_load, rs1, rs2.
  - On an advance cycle: ID→ex (or an invalid entry when bubble/flush), ex→mem, mem→wb.
  - When pipe_hold=1 all shadow stages hold.
- FSM states: RUN, FLUSH, HOLD.
  - RUN: mem_busy=1 → HOLD. Else branch_taken=1 → FLUSH if FLUSH_CYCLES>1, otherwise stay in RUN.
  - FLUSH: a down-counter loaded with FLUSH_CYCLES-1; return to RUN when it reaches 0. mem_busy pauses the count; branch_taken reloads it.
  - HOLD: return to the prior state (RUN or FLUSH) when mem_busy=0.
- Output priority, evaluated combinationally each cycle:
  1. mem_busy: pipe_hold=stall_if=stall_id=1; bubble_ex=0; flush_if_id=0; branch_taken is ignored (EX holds, so it re-presents later).
  2. branch_taken, or state FLUSH: flush_if_id=1, bubble_ex=1, stall_if=stall_id=0. A pending load-use on the squashed ID instruction is discarded.
  3. Load-use: ex.valid & ex.is_load & ex.wr & id_valid & ((uses_rs1 & rs1==ex.rd) | (uses_rs2 & rs2==ex.rd)) → stall_if=stall_id=bubble_ex=1 for exactly 1 cycle.
  4. Otherwise all controls are 0.
- Forwarding for the EX instruction:
  - MEM match (mem.valid & mem.wr & mem.rd==ex.rs) → 10.
  - Else WB match → 01.
  - Else 00.
  - rd=0 never matches. MEM has priority over WB for the same register.
- Latency: all controls are combinational from current inputs and state, with zero cycle delay.
- Reset (asynchronous): all shadow valids=0, state=RUN, counter=0; all outputs 0 and fwd sels 00.
- Reset mid-flush or mid-hold aborts immediately.

Optional Feature:
- HAZ_PERF_CNT_EN defined: adds output ports stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each load-use stall cycle; flush_cnt increments on each cycle flush_if_id=1.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Back-to-back dependency: add x5,x1,x2 then sub x6,x5,x3 → next cycle fwd_a_sel=10. Third instruction using x5 → fwd sel=01. No stall.
- Load-use: lw x7,0(x1) followed by add x8,x7,x2 → stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, then fwd_a_sel=01.
- x0 destination: addi x0,x0,1 followed by add x9,x0,x0 → fwd sels stay 00, no stall.
- Taken branch with FLUSH_CYCLES=2: branch_taken pulse → flush_if_id=1 for 2 cycles, bubble_ex=1 for both. A load-use in ID during the flush produces no stall.
- mem_busy held 3 cycles during a load-use window: pipe_hold=1 for those 3 cycles with bubble_ex=0. After release the single load-use stall cycle then occurs.
- Async reset asserted mid-FLUSH → all outputs 0 within the same cycle. After release the state is RUN and a dependent pair forwards correctly.
